operand_fetch_stage: RTL and testbench

Decode-to-execute operand stage sitting directly downstream of the 32x32 two-port register file. It consumes the asynchronous read ports PA/PB selected by RA/RB and applies forwarding from the EX, MEM and WB stages, so the write-at-edge register file never supplies stale data. It detects load-use hazards and stalls decode. It registers the resolved operands and control into the ID/EX pipeline latch.

---
 rtl/operand_fetch_stage.sv | 101 ++++++++++
 tb/tb_operand_fetch_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Operand fetch for the ID/EX boundary: register-file read with EX/MEM/WB
// forwarding, load-use hazard detection and the ID/EX pipeline latch.
module operand_fetch_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  RA,
  input  logic [4:0]  RB,
  input  logic [31:0] PA,
  input  logic [31:0] PB,
  input  logic        id_valid,
  input  logic        id_useA,
  input  logic        id_useB,
  input  logic [4:0]  id_RW,
  input  logic        id_LE,
  input  logic        id_is_load,
  input  logic [31:0] ex_Y,
  input  logic [31:0] mem_Y,
  input  logic [4:0]  mem_RW,
  input  logic        mem_LE,
  input  logic [31:0] PW,
  input  logic [4:0]  RW,
  input  logic        LE,
  input  logic        hold,
  input  logic        flush,
  output logic [31:0] ex_A,
  output logic [31:0] ex_B,
  output logic [4:0]  ex_RW,
  output logic        ex_LE,
  output logic        ex_is_load,
  output logic        ex_valid,
  output logic        stall
);

  logic        ex_fwd_en;
  logic        load_use;
  logic [31:0] opnd_a;
  logic [31:0] opnd_b;

  // A load in EX has no data yet, so it is never a forwarding source.
  assign ex_fwd_en = ex_valid & ex_LE & ~ex_is_load;

  // Youngest producer wins; r0 is hard-wired to zero regardless of writers.
  function automatic logic [31:0] fwd(
    input logic [4:0]  src,
    input logic [31:0] rf_data,
    input logic        ex_en,
    input logic [4:0]  ex_dst,
    input logic [31:0] ex_data,
    input logic        mem_en,
    input logic [4:0]  mem_dst,
    input logic [31:0] mem_data,
    input logic        wb_en,
    input logic [4:0]  wb_dst,
    input logic [31:0] wb_data
  );
    if (src == 5'd0)                     return 32'h0;
    else if (ex_en  && ex_dst  == src)   return ex_data;
    else if (mem_en && mem_dst == src)   return mem_data;
    else if (wb_en  && wb_dst  == src)   return wb_data;
    else                                 return rf_data;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    opnd_a   = 32'h0;
    opnd_b   = 32'h0;
    load_use = 1'b0;
    opnd_a = fwd(RA, PA, ex_fwd_en, ex_RW, ex_Y, mem_LE, mem_RW, mem_Y, LE, RW, PW);
    opnd_b = fwd(RB, PB, ex_fwd_en, ex_RW, ex_Y, mem_LE, mem_RW, mem_Y, LE, RW, PW);
    load_use = id_valid & ex_valid & ex_is_load & ex_LE & (ex_RW != 5'd0) &
               ((id_useA & (RA == ex_RW)) | (id_useB & (RB == ex_RW)));
  end

  assign stall = hold | load_use;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_A       <= 32'h0;
      ex_B       <= 32'h0;
      ex_RW      <= 5'd0;
      ex_LE      <= 1'b0;
      ex_is_load <= 1'b0;
      ex_valid   <= 1'b0;
    end else if (flush || (!hold && load_use)) begin
      // Bubble: controls cleared, operands left as they were.
      ex_RW      <= 5'd0;
      ex_LE      <= 1'b0;
      ex_is_load <= 1'b0;
      ex_valid   <= 1'b0;
    end else if (!hold) begin
      ex_A       <= opnd_a;
      ex_B       <= opnd_b;
      ex_RW      <= id_RW;
      ex_LE      <= id_LE & id_valid;
      ex_is_load <= id_is_load & id_valid;
      ex_valid   <= id_valid;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed-vector bench for operand_fetch_stage: reset, forwarding priority,
// load-use stall, register zero, flush/hold interaction and reset mid-stall.
module tb_operand_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic [4:0]  RA, RB;
  logic [31:0] PA, PB;
  logic        id_valid, id_useA, id_useB;
  logic [4:0]  id_RW;
  logic        id_LE, id_is_load;
  logic [31:0] ex_Y, mem_Y;
  logic [4:0]  mem_RW;
  logic        mem_LE;
  logic [31:0] PW;
  logic [4:0]  RW;
  logic        LE;
  logic        hold, flush;
  logic [31:0] ex_A, ex_B;
  logic [4:0]  ex_RW;
  logic        ex_LE, ex_is_load, ex_valid;
  logic        stall;

  int n_vec = 0;
  int n_err = 0;

  operand_fetch_stage dut (
    .clk(clk), .reset_n(reset_n),
    .RA(RA), .RB(RB), .PA(PA), .PB(PB),
    .id_valid(id_valid), .id_useA(id_useA), .id_useB(id_useB),
    .id_RW(id_RW), .id_LE(id_LE), .id_is_load(id_is_load),
    .ex_Y(ex_Y), .mem_Y(mem_Y), .mem_RW(mem_RW), .mem_LE(mem_LE),
    .PW(PW), .RW(RW), .LE(LE),
    .hold(hold), .flush(flush),
    .ex_A(ex_A), .ex_B(ex_B), .ex_RW(ex_RW),
    .ex_LE(ex_LE), .ex_is_load(ex_is_load), .ex_valid(ex_valid),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RA = 0; RB = 0; PA = 0; PB = 0;
    id_valid = 0; id_useA = 0; id_useB = 0;
    id_RW = 0; id_LE = 0; id_is_load = 0;
    ex_Y = 0; mem_Y = 0; mem_RW = 0; mem_LE = 0;
    PW = 0; RW = 0; LE = 0; hold = 0; flush = 0;
  endtask

  task automatic issue(input logic [4:0] ra, input logic [31:0] pa,
                       input logic [4:0] rb, input logic [31:0] pb,
                       input logic [4:0] rw, input logic ld);
    RA = ra; PA = pa; RB = rb; PB = pb;
    id_valid = 1; id_useA = 1; id_useB = 1;
    id_RW = rw; id_LE = 1; id_is_load = ld;
  endtask

  initial begin
    logic rnd_hold;
    idle();
    reset_n = 0;
    #1;

    // Reset with random inputs on both edges
    for (int i = 0; i < 2; i++) begin
      {RA, RB, id_RW, mem_RW, RW} = 25'($urandom);
      PA = $urandom; PB = $urandom; ex_Y = $urandom; mem_Y = $urandom; PW = $urandom;
      {id_valid, id_useA, id_useB, id_LE, id_is_load, mem_LE, LE, flush} = 8'($urandom);
      rnd_hold = 1'($urandom);
      hold = rnd_hold;
      tick();
      check("rst_ex_A", ex_A, 0);
      check("rst_ex_B", ex_B, 0);
      check("rst_ex_RW", 32'(ex_RW), 0);
      check("rst_ctrl", {29'b0, ex_LE, ex_is_load, ex_valid}, 0);
      check("rst_stall", 32'(stall), 32'(rnd_hold));
    end

    // Release; first decode appears one edge later
    idle();
    reset_n = 1;
    issue(5'd3, 32'h11, 5'd4, 32'h22, 5'd9, 0);
    #1;
    check("nohaz_stall", 32'(stall), 0);
    tick();
    check("nohaz_A", ex_A, 32'h11);
    check("nohaz_B", ex_B, 32'h22);
    check("nohaz_RW", 32'(ex_RW), 9);
    check("nohaz_ctrl", {29'b0, ex_LE, ex_is_load, ex_valid}, 32'b101);

    // Producer of r5 into EX
    issue(5'd1, 32'h1, 5'd2, 32'h2, 5'd5, 0);
    tick();
    // EX, MEM and WB all write r5: EX wins
    issue(5'd5, 32'h77, 5'd4, 32'h22, 5'd0, 0);
    id_LE = 0;
    ex_Y = 32'hA; mem_RW = 5; mem_LE = 1; mem_Y = 32'hB; RW = 5; LE = 1; PW = 32'hC;
    tick();
    check("fwd_ex_A", ex_A, 32'hA);
    check("fwd_ex_B", ex_B, 32'h22);
    // EX no longer writes r5 (latched id_LE=0): MEM wins, on B too
    RB = 5;
    tick();
    check("fwd_mem_A", ex_A, 32'hB);
    check("fwd_mem_B", ex_B, 32'hB);
    mem_LE = 0;
    tick();
    check("fwd_wb_A", ex_A, 32'hC);
    LE = 0;
    tick();
    check("fwd_rf_A", ex_A, 32'h77);
    check("fwd_rf_B", ex_B, 32'h22);

    // Invalid decode is a bubble and never writes
    issue(5'd3, 32'h11, 5'd4, 32'h22, 5'd12, 1);
    id_valid = 0;
    tick();
    check("inv_ctrl", {29'b0, ex_LE, ex_is_load, ex_valid}, 0);

    // Load-use: lw r7 then use of r7 on B
    idle();
    issue(5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 1);
    tick();
    check("lw_is_load", 32'(ex_is_load), 1);
    issue(5'd3, 32'h11, 5'd7, 32'h5555, 5'd8, 0);
    #1;
    check("lu_stall", 32'(stall), 1);
    tick();
    check("lu_bubble", {27'b0, ex_RW, ex_LE, ex_is_load, ex_valid}, 0);
    check("lu_A_held", ex_A, 0);
    mem_RW = 7; mem_LE = 1; mem_Y = 32'hDEAD;
    #1;
    check("lu_stall_end", 32'(stall), 0);
    tick();
    check("lu_B_mem", ex_B, 32'hDEAD);
    check("lu_A", ex_A, 32'h11);
    check("lu_RW", 32'(ex_RW), 8);

    // Register zero: load to r0 in EX, every stage targeting r0
    idle();
    issue(5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 1);
    tick();
    issue(5'd0, 32'hFFFF, 5'd0, 32'h1234, 5'd6, 0);
    ex_Y = 32'h99; mem_RW = 0; mem_LE = 1; mem_Y = 32'h88; RW = 0; LE = 1; PW = 32'h77;
    #1;
    check("r0_stall", 32'(stall), 0);
    tick();
    check("r0_A", ex_A, 0);
    check("r0_B", ex_B, 0);
    check("r0_RW", 32'(ex_RW), 6);

    // Flush with hold: bubble still inserted
    idle();
    issue(5'd3, 32'h11, 5'd4, 32'h22, 5'd10, 0);
    flush = 1; hold = 1;
    #1;
    check("fh_stall", 32'(stall), 1);
    tick();
    check("fh_bubble", {27'b0, ex_RW, ex_LE, ex_is_load, ex_valid}, 0);
    check("fh_A_held", ex_A, 0);
    flush = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_stall", 32'(stall), 1);
      tick();
      check("hold_frozen", {27'b0, ex_RW, ex_LE, ex_is_load, ex_valid}, 0);
      check("hold_A", ex_A, 0);
    end
    hold = 0;
    tick();
    check("rel_A", ex_A, 32'h11);
    check("rel_RW", 32'(ex_RW), 10);
    check("rel_valid", 32'(ex_valid), 1);

    // Hold over a load-use: no bubble, latch frozen
    issue(5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 1);
    tick();
    issue(5'd7, 32'h3333, 5'd4, 32'h22, 5'd8, 0);
    hold = 1;
    tick();
    check("hlu_frozen", {27'b0, ex_RW, ex_LE, ex_is_load, ex_valid}, {27'd7, 3'b111});
    check("hlu_stall", 32'(stall), 1);

    // Reset mid-stall: latch clears, stall falls to hold
    hold = 0;
    #1;
    check("rms_stall_pre", 32'(stall), 1);
    reset_n = 0;
    tick();
    check("rms_ctrl", {27'b0, ex_RW, ex_LE, ex_is_load, ex_valid}, 0);
    check("rms_stall", 32'(stall), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
